// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered channel multiplexer:
// arbitration mode constants, output-stage state encoding and grant width helper.
package mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Width of a grant index; a single channel still gets a one-bit index.
   function automatic int sel_width(input int n);
      int w;
      if (n <= 1) begin
         w = 1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter. In round-robin mode the search starts at ptr
// and wraps from N-1 back to 0; in fixed mode the lowest requesting index wins.
// With en low no grant is issued.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N    = 2,
   parameter int MODE = MODE_RR,
   localparam int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   // Rotating priority search: first requester at or after the start index wins.
   always_comb begin
      logic             found_v;
      int               start_v;
      int               idx_v;
      logic [SEL_W-1:0] idx_sel_v;
      grant     = '0;
      grant_idx = '0;
      found_v   = 1'b0;
      idx_v     = 0;
      idx_sel_v = '0;
      if (MODE == MODE_FIXED) begin
         start_v = 0;
      end else begin
         start_v = int'(ptr);
      end
      if (en) begin
         for (int k = 0; k < N; k++) begin
            idx_v     = (start_v + k) % N;
            idx_sel_v = SEL_W'(idx_v);
            if (!found_v && req[idx_sel_v]) begin
               found_v          = 1'b1;
               grant[idx_sel_v] = 1'b1;
               grant_idx        = idx_sel_v;
            end else begin
            end
         end
      end else begin
         grant = '0;
      end
   end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 registered channel multiplexer with valid/ready on every port.
// An internal arbiter picks the channel; the chosen word is held in an output
// register until the consumer takes it. Data never passes combinationally from
// in_data to out_data; in_ready depends only on in_valid, out_ready and state.
module mux_nto1_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 2,
   parameter int MODE  = MODE_RR,
   localparam int SEL_W = sel_width(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   out_state_e       state_r;
   logic [WIDTH-1:0] data_r;
   logic [SEL_W-1:0] sel_r;
   logic [SEL_W-1:0] ptr_r;

   logic             load_en_s;
   logic [N-1:0]     grant_s;
   logic [SEL_W-1:0] grant_idx_s;
   logic             xfer_s;
   logic [WIDTH-1:0] mux_data_s;
   logic [SEL_W-1:0] ptr_next_s;

   // The register may take a new word when empty or when its word leaves this cycle.
   assign load_en_s = (state_r == ST_EMPTY) || out_ready;

   rr_arbiter #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_r),
      .en        (load_en_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   // Grants only go to requesting channels, so any grant bit is a transfer.
   assign in_ready = rst ? '0 : grant_s;
   assign xfer_s   = |grant_s;

   // One-hot AND-OR select of the granted channel's data.
   always_comb begin
      mux_data_s = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_s[i]) begin
            mux_data_s = in_data[i*WIDTH +: WIDTH];
         end else begin
         end
      end
   end

   // Next round-robin start: one past the granted channel, wrapping at N-1.
   always_comb begin
      if (int'(grant_idx_s) == N - 1) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = grant_idx_s + SEL_W'(1);
      end
   end

   // Output-stage FSM with its data, index and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         data_r  <= '0;
         sel_r   <= '0;
         ptr_r   <= '0;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (xfer_s) begin
                  state_r <= ST_FULL;
               end else begin
                  state_r <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_ready && !xfer_s) begin
                  state_r <= ST_EMPTY;
               end else begin
                  state_r <= ST_FULL;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
            end
         endcase
         if (xfer_s) begin
            data_r <= mux_data_s;
            sel_r  <= grant_idx_s;
            if (MODE == MODE_RR) begin
               ptr_r <= ptr_next_s;
            end else begin
               ptr_r <= ptr_r;
            end
         end else begin
            data_r <= data_r;
            sel_r  <= sel_r;
            ptr_r  <= ptr_r;
         end
      end
   end

   assign out_valid = (state_r == ST_FULL);
   assign out_data  = data_r;
   assign out_sel   = sel_r;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: three instances (N=4 round-robin, N=4 fixed priority,
// N=1 pipe). A queue-based reference model predicts every accepted word and
// in_ready each cycle; a monitor pops and compares whenever a DUT word is
// consumed. Directed sequences cover fairness, priority, stall, drain, reset.
module tb_mux_nto1_rr;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Per-instance stimulus (index 0 = rr, 1 = fixed, 2 = N=1 pipe)
   logic [3:0]  vld  [3];
   logic        ordy [3];
   logic [31:0] dat  [3][4];

   // Per-instance observed outputs
   logic [3:0]  rdy [3];
   logic        ov  [3];
   logic [31:0] od  [3];
   logic [1:0]  os  [3];

   logic [127:0] din_rr, din_fx;
   logic [3:0]   rdy_rr, rdy_fx;
   logic [0:0]   rdy_p1, sel_p1;
   logic [1:0]   sel_rr, sel_fx;
   logic         ov_rr, ov_fx, ov_p1;
   logic [31:0]  od_rr, od_fx, od_p1;

   assign din_rr = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
   assign din_fx = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};

   mux_nto1_rr #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(din_rr), .in_ready(rdy_rr),
      .out_valid(ov_rr), .out_data(od_rr), .out_sel(sel_rr), .out_ready(ordy[0]));

   mux_nto1_rr #(.WIDTH(32), .N(4), .MODE(1)) u_fx (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(din_fx), .in_ready(rdy_fx),
      .out_valid(ov_fx), .out_data(od_fx), .out_sel(sel_fx), .out_ready(ordy[1]));

   mux_nto1_rr #(.WIDTH(32), .N(1), .MODE(0)) u_p1 (
      .clk(clk), .rst(rst), .in_valid(vld[2][0]), .in_data(dat[2][0]), .in_ready(rdy_p1),
      .out_valid(ov_p1), .out_data(od_p1), .out_sel(sel_p1), .out_ready(ordy[2]));

   assign rdy[0] = rdy_rr;
   assign rdy[1] = rdy_fx;
   assign rdy[2] = {3'b000, rdy_p1};
   assign ov[0]  = ov_rr;
   assign ov[1]  = ov_fx;
   assign ov[2]  = ov_p1;
   assign od[0]  = od_rr;
   assign od[1]  = od_fx;
   assign od[2]  = od_p1;
   assign os[0]  = sel_rr;
   assign os[1]  = sel_fx;
   assign os[2]  = {1'b0, sel_p1};

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic       mv   [3];
   int         mptr [3];
   logic [3:0] hold [3];
   logic [33:0] q0[$], q1[$], q2[$];

   function automatic int nch(input int m);
      return (m == 2) ? 1 : 4;
   endfunction

   task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d got=%h want=%h", nm, m, got, want);
      end
   endtask

   task automatic qpush(input int m, input logic [33:0] v);
      case (m)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   function automatic int qsize(input int m);
      case (m)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpop(input int m, output logic [33:0] v);
      case (m)
         0: v = q0.pop_front();
         1: v = q1.pop_front();
         default: v = q2.pop_front();
      endcase
   endtask

   task automatic qclear(input int m);
      case (m)
         0: q0.delete();
         1: q1.delete();
         default: q2.delete();
      endcase
   endtask

   // Behavioural model of one cycle for instance m, evaluated before the clock edge.
   task automatic model(input int m);
      int n, g, c;
      logic le;
      logic [3:0] er;
      n = nch(m);
      if (rst) begin
         mv[m] = 1'b0;
         mptr[m] = 0;
         hold[m] = 4'd0;
         qclear(m);
         chk("rst_in_ready", m, 32'(rdy[m]), 32'd0);
      end else begin
         chk("out_valid", m, 32'(ov[m]), 32'(mv[m]));
         le = !mv[m] || ordy[m];
         g = -1;
         if (le) begin
            for (int k = 0; k < n; k++) begin
               c = (m == 1) ? k : (mptr[m] + k) % n;
               if (g < 0 && vld[m][c]) g = c;
            end
         end
         er = (g >= 0) ? 4'(1 << g) : 4'd0;
         chk("in_ready", m, 32'(rdy[m]), 32'(er));
         hold[m] = vld[m] & ~er;
         if (g >= 0) begin
            qpush(m, {g[1:0], dat[m][g]});
            mv[m] = 1'b1;
            if (m != 1) mptr[m] = (g + 1) % n;
         end else if (le) begin
            mv[m] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      #1;
      for (int m = 0; m < 3; m++) model(m);
      @(negedge clk);
   endtask

   // Scoreboard monitor: compare each word as the consumer takes it.
   always @(negedge clk) begin
      logic [33:0] e;
      #2;
      if (!rst) begin
         for (int m = 0; m < 3; m++) begin
            if (ov[m] && ordy[m]) begin
               if (qsize(m) == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_empty dut%0d got=word %h want=no word", m, od[m]);
               end else begin
                  qpop(m, e);
                  chk("sb_data", m, od[m], e[31:0]);
                  chk("sb_sel", m, 32'(os[m]), 32'(e[33:32]));
               end
            end
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1;
      for (int m = 0; m < 3; m++) begin
         vld[m] = 4'd0; ordy[m] = 1'b0; hold[m] = 4'd0; mv[m] = 1'b0; mptr[m] = 0;
         for (int i = 0; i < 4; i++) dat[m][i] = 32'd0;
      end
      #1;
      for (int m = 0; m < 3; m++) begin
         chk("reset_valid", m, 32'(ov[m]), 32'd0);
         chk("reset_data", m, od[m], 32'd0);
         chk("reset_sel", m, 32'(os[m]), 32'd0);
      end
      @(negedge clk);
      cyc();

      // Fairness on rr and fixed priority on fx, in parallel
      rst = 1'b0;
      vld[0] = 4'hF;
      vld[1] = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         dat[0][i] = 32'hA0 + 32'(i);
         dat[1][i] = 32'hB0 + 32'(i);
      end
      ordy[0] = 1'b1;
      ordy[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("rr_seq_valid", 0, 32'(ov[0]), 32'd1);
         chk("rr_seq_sel", 0, 32'(os[0]), 32'(k % 4));
         chk("rr_seq_data", 0, od[0], 32'hA0 + 32'(k % 4));
         chk("fx_sel", 1, 32'(os[1]), 32'd1);
         chk("fx_rdy3", 1, 32'(rdy[1][3]), 32'd0);
      end
      vld[1] = 4'd0;

      // Backpressure on rr with channel 2
      vld[0] = 4'b0100;
      dat[0][2] = 32'h1234_5678;
      cyc();
      chk("bp_load_data", 0, od[0], 32'h1234_5678);
      dat[0][2] = 32'hCAFE_0002;
      ordy[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_rdy", 0, 32'(rdy[0]), 32'd0);
         chk("bp_data", 0, od[0], 32'h1234_5678);
         chk("bp_sel", 0, 32'(os[0]), 32'd2);
      end
      ordy[0] = 1'b1;
      cyc();
      chk("bp_release_valid", 0, 32'(ov[0]), 32'd1);
      chk("bp_release_data", 0, od[0], 32'hCAFE_0002);

      // Skip idle channels, then drain
      vld[0] = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("skip_sel", 0, 32'(os[0]), 32'd0);
         chk("skip_valid", 0, 32'(ov[0]), 32'd1);
      end
      vld[0] = 4'd0;
      cyc();
      chk("drain_valid", 0, 32'(ov[0]), 32'd0);
      chk("drain_data_kept", 0, od[0], 32'hA0);

      // Randomized traffic on all three instances
      repeat (400) begin
         for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < nch(m); i++) begin
               if (!hold[m][i]) begin
                  vld[m][i] = ($urandom_range(0, 2) != 0);
                  dat[m][i] = (m == 2) ? 32'hDEAD_BEEF + 32'($urandom_range(0, 255)) : $urandom;
               end
            end
            ordy[m] = ($urandom_range(0, 3) != 0);
         end
         cyc();
      end

      // Asynchronous reset with a word held in rr
      vld[0] = 4'hF;
      ordy[0] = 1'b0;
      cyc();
      chk("pre_rst_valid", 0, 32'(ov[0]), 32'd1);
      rst = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         chk("async_rst_valid", m, 32'(ov[m]), 32'd0);
         chk("async_rst_data", m, od[m], 32'd0);
         chk("async_rst_sel", m, 32'(os[m]), 32'd0);
      end
      cyc();
      rst = 1'b0;
      for (int m = 0; m < 3; m++) begin
         vld[m] = 4'd0;
         ordy[m] = 1'b1;
      end
      vld[0] = 4'hF;
      cyc();
      chk("post_rst_sel", 0, 32'(os[0]), 32'd0);
      chk("post_rst_valid", 0, 32'(ov[0]), 32'd1);

      // Drain everything still expected
      vld[0] = 4'd0;
      guard = 0;
      while ((qsize(0) + qsize(1) + qsize(2)) > 0 && guard < 20) begin
         cyc();
         guard++;
      end
      for (int m = 0; m < 3; m++) chk("final_queue_empty", m, 32'(qsize(m)), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
